// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch/jump resolver plus a direct-mapped
// branch target buffer with per-entry saturating direction counters.
// IF looks up the BTB combinationally every cycle, EX resolutions train it,
// and a mispredict flag with its redirect PC lets the pipeline flush IF/ID.
// Saturating branch and mispredict counters support performance measurement.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [31:0]       imm,
  input  logic              branch,
  input  logic              jalr_sel,
  input  logic [31:0]       alu_result,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic [31:0]       pc_plus_4,
  output logic [31:0]       pc_plus_imm,
  output logic [31:0]       branch_target,
  output logic              actual_taken,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mp_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_WEAK_T  = CNT_W'(1'b1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1'b1);
  localparam logic [STAT_W-1:0] STAT_MAX    = {STAT_W{1'b1}};

  // BTB storage
  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [PC_W-1:0]   target_r [ENTRIES];
  logic [CNT_W-1:0]  cnt_r    [ENTRIES];
  logic [STAT_W-1:0] br_count_r;
  logic [STAT_W-1:0] mp_count_r;

  logic [IDX_W-1:0]  f_idx_s;
  logic [TAG_W-1:0]  f_tag_s;
  logic              f_hit_s;
  logic [31:0]       ex_pc_ext_s;
  logic              ctl_s;
  logic [IDX_W-1:0]  t_idx_s;
  logic [TAG_W-1:0]  t_tag_s;
  logic              t_hit_s;
  logic              t_wr_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [PC_W-1:0]   tgt_nxt_s;

  // Byte-offset bits of the PCs never select an entry; folded here on purpose.
  logic unused_s;
  assign unused_s = ^{fetch_pc[1:0], ex_pc[1:0]};

  // IF lookup: hit needs valid entry with matching tag; direction from counter MSB.
  always_comb begin
    f_idx_s    = fetch_pc[IDX_W+1:2];
    f_tag_s    = fetch_pc[PC_W-1:IDX_W+2];
    f_hit_s    = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    pred_taken = f_hit_s & cnt_r[f_idx_s][CNT_W-1];
    if (pred_taken) begin
      pred_target = target_r[f_idx_s];
    end else begin
      pred_target = fetch_pc + PC_W'(4);
    end
  end

  // EX resolution: direction, target, and comparison against the carried prediction.
  always_comb begin
    ex_pc_ext_s  = 32'(ex_pc);
    pc_plus_4    = ex_pc_ext_s + 32'd4;
    pc_plus_imm  = ex_pc_ext_s + imm;
    actual_taken = jalr_sel | (branch & alu_result[0]);
    if (jalr_sel) begin
      branch_target = alu_result & 32'hFFFF_FFFE;
    end else begin
      branch_target = ex_pc_ext_s + (imm << 1);
    end
    ctl_s      = ex_valid & (branch | jalr_sel);
    mispredict = ctl_s & ((actual_taken != ex_pred_taken) |
                          (actual_taken & (ex_pred_target != branch_target[PC_W-1:0])));
    if (actual_taken) begin
      redirect_pc = branch_target;
    end else begin
      redirect_pc = pc_plus_4;
    end
  end

  // Training next-state for the entry addressed by the resolving instruction.
  always_comb begin
    t_idx_s = ex_pc[IDX_W+1:2];
    t_tag_s = ex_pc[PC_W-1:IDX_W+2];
    t_hit_s = valid_r[t_idx_s] && (tag_r[t_idx_s] == t_tag_s);
    // A miss only allocates when the branch was actually taken.
    t_wr_s  = ctl_s & (t_hit_s | actual_taken);
    if (!t_hit_s) begin
      cnt_nxt_s = CNT_WEAK_T;
    end else if (actual_taken) begin
      if (cnt_r[t_idx_s] == CNT_MAX) begin
        cnt_nxt_s = CNT_MAX;
      end else begin
        cnt_nxt_s = cnt_r[t_idx_s] + CNT_W'(1'b1);
      end
    end else begin
      if (cnt_r[t_idx_s] == CNT_ZERO) begin
        cnt_nxt_s = CNT_ZERO;
      end else begin
        cnt_nxt_s = cnt_r[t_idx_s] - CNT_W'(1'b1);
      end
    end
    if (actual_taken) begin
      tgt_nxt_s = branch_target[PC_W-1:0];
    end else begin
      tgt_nxt_s = target_r[t_idx_s];
    end
  end

  // BTB update: reset clears every entry to weakly-not-taken, otherwise write the trained entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {PC_W{1'b0}};
        cnt_r[i]    <= CNT_WEAK_NT;
      end
    end else if (t_wr_s) begin
      valid_r[t_idx_s]  <= 1'b1;
      tag_r[t_idx_s]    <= t_tag_s;
      target_r[t_idx_s] <= tgt_nxt_s;
      cnt_r[t_idx_s]    <= cnt_nxt_s;
    end
  end

  // Saturating statistics for resolved control instructions and mispredictions.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_r <= {STAT_W{1'b0}};
      mp_count_r <= {STAT_W{1'b0}};
    end else begin
      if (ctl_s && (br_count_r != STAT_MAX)) begin
        br_count_r <= br_count_r + STAT_W'(1'b1);
      end
      if (mispredict && (mp_count_r != STAT_MAX)) begin
        mp_count_r <= mp_count_r + STAT_W'(1'b1);
      end
    end
  end

  assign br_count = br_count_r;
  assign mp_count = mp_count_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed scenarios followed by random
// traffic, all checked against a table-of-records reference model.
module tb_branch_predict_unit;

  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int PC_MOD  = 1 << PC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic [31:0]      imm;
  logic             branch;
  logic             jalr_sel;
  logic [31:0]      alu_result;
  logic             ex_pred_taken;
  logic [PC_W-1:0]  ex_pred_target;
  logic [31:0]      pc_plus_4, pc_plus_imm, branch_target, redirect_pc;
  logic             actual_taken, mispredict;
  logic [15:0]      br_count, mp_count;

  logic             d2_pred_taken, d2_actual_taken, d2_mispredict;
  logic [PC_W-1:0]  d2_pred_target;
  logic [31:0]      d2_pc_plus_4, d2_pc_plus_imm, d2_branch_target, d2_redirect_pc;
  logic [1:0]       d2_br_count, d2_mp_count;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(2), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .imm(imm),
    .branch(branch), .jalr_sel(jalr_sel), .alu_result(alu_result),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_plus_4(pc_plus_4), .pc_plus_imm(pc_plus_imm), .branch_target(branch_target),
    .actual_taken(actual_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count));

  // Narrow-statistics instance sharing the same stimulus.
  branch_predict_unit #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(2), .STAT_W(2)) dut2 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(d2_pred_taken),
    .pred_target(d2_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .imm(imm),
    .branch(branch), .jalr_sel(jalr_sel), .alu_result(alu_result),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_plus_4(d2_pc_plus_4), .pc_plus_imm(d2_pc_plus_imm), .branch_target(d2_branch_target),
    .actual_taken(d2_actual_taken), .mispredict(d2_mispredict), .redirect_pc(d2_redirect_pc),
    .br_count(d2_br_count), .mp_count(d2_mp_count));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per BTB slot, counters as plain integers.
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned tgt;
    int          cnt;
  } ent_t;

  ent_t        tbl [ENTRIES];
  int unsigned m_br, m_mp;

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      tbl[i].v = 1'b0; tbl[i].tag = 0; tbl[i].tgt = 0; tbl[i].cnt = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_pred(input int unsigned pc, output bit t, output int unsigned tgt);
    ent_t e;
    e = tbl[idx_of(pc)];
    t = e.v && (e.tag == tag_of(pc)) && (e.cnt >= 2);
    tgt = t ? e.tgt : (pc + 4) % PC_MOD;
  endfunction

  function automatic void model_resolve(output bit ctl, output bit taken,
                                        output bit [31:0] bt, output bit mp);
    bit [31:0] pcx;
    pcx   = 32'(ex_pc);
    ctl   = ex_valid && (branch || jalr_sel);
    taken = jalr_sel || (branch && alu_result[0]);
    bt    = jalr_sel ? {alu_result[31:1], 1'b0} : pcx + imm * 32'd2;
    mp    = ctl && ((taken != ex_pred_taken) ||
                    (taken && (32'(ex_pred_target) != bt % PC_MOD)));
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_clock();
    bit ctl, taken, mp;
    bit [31:0] bt;
    int unsigned i;
    bit hit;
    if (reset) begin
      model_reset();
    end else begin
      model_resolve(ctl, taken, bt, mp);
      if (ctl) begin
        m_br++;
        if (mp) m_mp++;
        i   = idx_of(ex_pc);
        hit = tbl[i].v && (tbl[i].tag == tag_of(ex_pc));
        if (hit) begin
          tbl[i].cnt = taken ? ((tbl[i].cnt < 3) ? tbl[i].cnt + 1 : 3)
                             : ((tbl[i].cnt > 0) ? tbl[i].cnt - 1 : 0);
          if (taken) tbl[i].tgt = bt % PC_MOD;
        end else if (taken) begin
          tbl[i].v = 1'b1; tbl[i].tag = tag_of(ex_pc); tbl[i].tgt = bt % PC_MOD; tbl[i].cnt = 2;
        end
      end
    end
  endfunction

  task automatic check_all();
    bit pt, ctl, taken, mp;
    int unsigned ptg;
    bit [31:0] bt;
    model_pred(fetch_pc, pt, ptg);
    model_resolve(ctl, taken, bt, mp);
    check("pred_taken", pred_taken, pt);
    check("pred_target", pred_target, ptg);
    check("pc_plus_4", pc_plus_4, 32'(ex_pc) + 32'd4);
    check("pc_plus_imm", pc_plus_imm, 32'(ex_pc) + imm);
    check("branch_target", branch_target, bt);
    check("actual_taken", actual_taken, taken);
    check("mispredict", mispredict, mp);
    if (mp) check("redirect_pc", redirect_pc, taken ? bt : 32'(ex_pc) + 32'd4);
    check("br_count", br_count, sat(m_br, 65535));
    check("mp_count", mp_count, sat(m_mp, 65535));
    check("br_count_w2", d2_br_count, sat(m_br, 3));
    check("mp_count_w2", d2_mp_count, sat(m_mp, 3));
  endtask

  // One cycle: check mid-cycle, advance model on the edge, then settle.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; branch = 1'b0; jalr_sel = 1'b0; ex_pc = 9'h000;
    imm = 32'd0; alu_result = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 9'h000;
  endtask

  task automatic br(input logic [PC_W-1:0] pc, input logic [31:0] im, input logic c,
                    input logic pt, input logic [PC_W-1:0] ptg);
    ex_valid = 1'b1; branch = 1'b1; jalr_sel = 1'b0; ex_pc = pc; imm = im;
    alu_result = {31'd0, c}; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  initial begin
    bit pt;
    int unsigned ptg;
    reset = 1'b1; fetch_pc = 9'h010; idle();
    model_reset();
    #1;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_pred_taken", pred_taken, 32'd0);
    check("rst_pred_target", pred_target, 32'h014);
    step();

    // Cold taken branch mispredicts and allocates.
    br(9'h020, 32'h8, 1'b1, 1'b0, 9'h024);
    #1;
    check("cold_target", branch_target, 32'h030);
    check("cold_mp", mispredict, 32'd1);
    check("cold_redirect", redirect_pc, 32'h030);
    step();
    idle(); fetch_pc = 9'h020;
    #1;
    check("cold_pred_taken", pred_taken, 32'd1);
    check("cold_pred_target", pred_target, 32'h030);
    check("cold_br_count", br_count, 32'd1);
    check("cold_mp_count", mp_count, 32'd1);
    step();

    // Hysteresis: two not-taken resolutions.
    br(9'h020, 32'h8, 1'b0, 1'b1, 9'h030);
    #1;
    check("hyst_mp1", mispredict, 32'd1);
    check("hyst_redirect", redirect_pc, 32'h024);
    step();
    check("hyst_pred_taken", pred_taken, 32'd0);
    br(9'h020, 32'h8, 1'b0, 1'b0, 9'h024);
    #1;
    check("hyst_mp2", mispredict, 32'd0);
    step();

    // Alias: 0x060 replaces index 8 with tag 1.
    br(9'h060, 32'h4, 1'b1, 1'b0, 9'h064);
    step();
    idle(); fetch_pc = 9'h020;
    #1;
    check("alias_pred_taken", pred_taken, 32'd0);
    check("alias_pred_target", pred_target, 32'h024);
    step();

    // jalr target compare.
    ex_valid = 1'b1; jalr_sel = 1'b1; ex_pc = 9'h040; alu_result = 32'h105;
    ex_pred_taken = 1'b1; ex_pred_target = 9'h104;
    #1;
    check("jalr_target", branch_target, 32'h104);
    check("jalr_mp0", mispredict, 32'd0);
    step();
    ex_pred_target = 9'h100;
    #1;
    check("jalr_mp1", mispredict, 32'd1);
    check("jalr_redirect", redirect_pc, 32'h104);
    step();

    // Same-cycle lookup and training of index 8: lookup sees old state.
    fetch_pc = 9'h060;
    br(9'h060, 32'h4, 1'b0, 1'b1, 9'h068);
    #1;
    check("rbw_pred_taken", pred_taken, 32'd1);
    check("rbw_pred_target", pred_target, 32'h068);
    step();

    // Reset with a live training request.
    reset = 1'b1;
    br(9'h060, 32'h4, 1'b1, 1'b0, 9'h064);
    step();
    reset = 1'b0; idle();
    #1;
    check("post_rst_pred", pred_taken, 32'd0);
    check("post_rst_br", br_count, 32'd0);
    check("post_rst_mp", mp_count, 32'd0);
    step();

    // Narrow statistics saturate.
    for (int i = 0; i < 5; i++) begin
      br(9'(32'h100 + 32'(i) * 32'd4), 32'h2, 1'($urandom_range(0, 1)), 1'b0, 9'h000);
      step();
    end
    idle();
    #1;
    check("w2_br_sat", d2_br_count, 32'd3);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      fetch_pc   = 9'($urandom_range(0, 127) * 4);
      ex_valid   = ($urandom_range(0, 7) != 0);
      ex_pc      = 9'($urandom_range(0, 127) * 4);
      imm        = 32'($urandom_range(0, 63)) - 32'd32;
      branch     = ($urandom_range(0, 2) != 0);
      jalr_sel   = ($urandom_range(0, 5) == 0);
      alu_result = (jalr_sel) ? 32'($urandom_range(0, 511)) : $urandom;
      model_pred(ex_pc, pt, ptg);
      if ($urandom_range(0, 3) != 0) begin
        ex_pred_taken = pt; ex_pred_target = 9'(ptg);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = 9'($urandom_range(0, 511));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
